// File: rtl/bit_fifo32_pkg.sv
// Shared constants and types for the 33-bit FIFO controller built around a
// 32x1 LUT RAM. The optional level/overflow outputs of bit_fifo32_ctrl are
// enabled with the macro BIT_FIFO32_LEVEL_EN.
package bit_fifo32_pkg;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Each cycle carries exactly one RAM operation: a write slot or a head refill.
    typedef enum logic [0:0] {
        SLOT_WRITE  = 1'b0,
        SLOT_REFILL = 1'b1
    } slot_e;

endpackage

// File: rtl/bit_fifo32_ptr.sv
// Wrap-around RAM pointer with increment enable; used for both write and read
// addresses of the FIFO. Wrap is the natural modulo-2**W overflow.
module bit_fifo32_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_en,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_r;

    // Pointer register: clear on reset, advance by one when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {W{1'b0}};
        end else if (inc_en) begin
            ptr_r <= ptr_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/bit_fifo32_ctrl.sv
// 1-bit FIFO controller: 32 bits live in an external 32x1 LUT RAM (falling-edge
// write, async read) and one more in the registered head bit OUT_D.
// The slot type (write or refill) is decided from registered state only, so
// RAM_A never depends on inputs. Empty-FIFO pushes bypass the RAM.
// Optional macro BIT_FIFO32_LEVEL_EN adds LEVEL (cnt + OUT_VALID) and a sticky
// OVF flag for pushes attempted while full.
module bit_fifo32_ctrl
    import bit_fifo32_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic              IN_D,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              OUT_D,
    output logic [ADDR_W-1:0] RAM_A,
    output logic              RAM_D,
    output logic              RAM_WE,
    input  logic              RAM_O
`ifdef BIT_FIFO32_LEVEL_EN
    ,
    output logic [CNT_W-1:0]  LEVEL,
    output logic              OVF
`endif
);

    logic [ADDR_W-1:0] wr_ptr_s;
    logic [ADDR_W-1:0] rd_ptr_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              out_valid_r;
    logic              out_valid_nxt_s;
    logic              out_d_r;
    logic              out_d_nxt_s;
    slot_e             slot_s;
    logic              in_ready_s;
    logic              push_s;
    logic              pop_s;
    logic              bypass_s;
    logic              ram_we_s;
    logic              ram_d_s;
    logic [ADDR_W-1:0] ram_a_s;
    logic              rd_inc_s;

    // Slot decision: refill the empty head register whenever RAM holds data.
    always_comb begin
        slot_s = SLOT_WRITE;
        if (!out_valid_r && (cnt_r != CNT_ZERO)) begin
            slot_s = SLOT_REFILL;
        end else begin
            slot_s = SLOT_WRITE;
        end
    end

    // Handshake and RAM control for the current slot; IN_READY is forced low in reset.
    always_comb begin
        in_ready_s = 1'b0;
        ram_a_s    = wr_ptr_s;
        rd_inc_s   = 1'b0;
        case (slot_s)
            SLOT_REFILL: begin
                in_ready_s = 1'b0;
                ram_a_s    = rd_ptr_s;
                rd_inc_s   = 1'b1;
            end
            SLOT_WRITE: begin
                in_ready_s = RST_N && (cnt_r != CNT_FULL);
                ram_a_s    = wr_ptr_s;
                rd_inc_s   = 1'b0;
            end
            default: begin
                in_ready_s = 1'b0;
                ram_a_s    = wr_ptr_s;
                rd_inc_s   = 1'b0;
            end
        endcase
        push_s   = IN_VALID && in_ready_s;
        pop_s    = out_valid_r && OUT_READY && (slot_s == SLOT_WRITE);
        bypass_s = push_s && (cnt_r == CNT_ZERO) && (!out_valid_r || OUT_READY);
        ram_we_s = push_s && !bypass_s;
        if (RST_N) begin
            ram_d_s = IN_D;
        end else begin
            ram_d_s = 1'b0;
        end
    end

    // Next occupancy and head-register contents.
    always_comb begin
        cnt_nxt_s       = cnt_r;
        out_valid_nxt_s = out_valid_r;
        out_d_nxt_s     = out_d_r;
        case (slot_s)
            SLOT_REFILL: begin
                cnt_nxt_s       = cnt_r - CNT_ONE;
                out_valid_nxt_s = 1'b1;
                out_d_nxt_s     = RAM_O;
            end
            SLOT_WRITE: begin
                if (ram_we_s) begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
                if (bypass_s) begin
                    out_valid_nxt_s = 1'b1;
                    out_d_nxt_s     = IN_D;
                end else if (pop_s) begin
                    out_valid_nxt_s = 1'b0;
                    out_d_nxt_s     = out_d_r;
                end else begin
                    out_valid_nxt_s = out_valid_r;
                    out_d_nxt_s     = out_d_r;
                end
            end
            default: begin
                cnt_nxt_s       = cnt_r;
                out_valid_nxt_s = out_valid_r;
                out_d_nxt_s     = out_d_r;
            end
        endcase
    end

    // Occupancy counter and head register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r       <= CNT_ZERO;
            out_valid_r <= 1'b0;
            out_d_r     <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_d_r     <= out_d_nxt_s;
        end
    end

    bit_fifo32_ptr #(.W(ADDR_W)) u_wr_ptr (
        .clk    (CLK),
        .rst_n  (RST_N),
        .inc_en (ram_we_s),
        .ptr    (wr_ptr_s)
    );

    bit_fifo32_ptr #(.W(ADDR_W)) u_rd_ptr (
        .clk    (CLK),
        .rst_n  (RST_N),
        .inc_en (rd_inc_s),
        .ptr    (rd_ptr_s)
    );

`ifdef BIT_FIFO32_LEVEL_EN
    logic [CNT_W-1:0] level_r;
    logic             ovf_r;

    // Total held bits (RAM plus head) and sticky push-while-full flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            level_r <= CNT_ZERO;
            ovf_r   <= 1'b0;
        end else begin
            level_r <= cnt_nxt_s + {{(CNT_W-1){1'b0}}, out_valid_nxt_s};
            ovf_r   <= ovf_r || (IN_VALID && !in_ready_s &&
                                 (slot_s == SLOT_WRITE) && (cnt_r == CNT_FULL));
        end
    end

    assign LEVEL = level_r;
    assign OVF   = ovf_r;
`endif

    assign IN_READY  = in_ready_s;
    assign OUT_VALID = out_valid_r;
    assign OUT_D     = out_d_r;
    assign RAM_A     = ram_a_s;
    assign RAM_D     = ram_d_s;
    assign RAM_WE    = ram_we_s;

endmodule

// File: doc/bit_fifo32_ctrl.md
Name: bit_fifo32_ctrl

Overview:
- Controller for a 1-bit-wide FIFO built on one external 32x1 single-port LUT RAM with a synchronous write. The RAM writes on the falling edge of WCLK and reads asynchronously.
- The block drives the RAM address, data and write-enable, and captures the RAM's asynchronous output into a registered head bit.
- It presents valid/ready stream interfaces on the push and pop sides. It sits directly upstream of the RAM and owns all of the RAM's control.

Parameters:
- ADDR_W, 5: RAM address width. DEPTH = 2**ADDR_W = 32 entries.
- CNT_W, 6: width of the occupancy counter. Must equal ADDR_W+1.

Ports:
- CLK  in  1  Single clock. Also tied externally to the RAM's WCLK.
- RST_N  in  1  Asynchronous active-low reset.
- IN_VALID  in  1  Push request.
- IN_READY  out  1  Push accepted when IN_VALID && IN_READY.
- IN_D  in  1  Push data bit.
- OUT_VALID  out  1  Head bit available (registered).
- OUT_READY  in  1  Pop acknowledge.
- OUT_D  out  1  Head bit (registered).
- RAM_A  out  ADDR_W  RAM address, driving A4..A0.
- RAM_D  out  1  RAM write data.
- RAM_WE  out  1  RAM write enable.
- RAM_O  in  1  Asynchronous RAM read data.

Behaviour:
- Reset (async, RST_N low):
  - wr_ptr=0, rd_ptr=0, cnt=0.
  - OUT_VALID=0, OUT_D=0.
  - RAM_WE=0, RAM_A=0, RAM_D=0.
  - IN_READY is held at 0 while reset is asserted.
- Reset in mid-operation discards all contents. RAM contents are not cleared and are never read before being rewritten.
- Storage model:
  - Total capacity is DEPTH+1 = 33 bits: 32 in RAM plus the OUT_D head register.
  - cnt counts RAM-resident bits only, range 0..32.
- One RAM operation per cycle. The slot type is decided from registered state only:
  - refill = !OUT_VALID && cnt!=0.
  - Refill cycle:
    - RAM_A=rd_ptr, RAM_WE=0, IN_READY=0.
    - At the rising edge: OUT_D<=RAM_O, OUT_VALID<=1, rd_ptr<=rd_ptr+1 (mod 32), cnt<=cnt-1.
  - Write cycle (!refill):
    - RAM_A=wr_ptr, RAM_D=IN_D.
    - IN_READY = (cnt!=DEPTH).
    - Pushes under bypass (below) skip the RAM, so RAM_WE = IN_VALID && IN_READY && !bypass.
    - The RAM latches the bit on the falling edge in mid-cycle. RAM_A and RAM_D are stable from the rising edge onward.
    - At the next rising edge, on a RAM write: wr_ptr<=wr_ptr+1 (mod 32), cnt<=cnt+1.
- Bypass (push goes straight to the head register, no RAM write):
  - Condition: cnt==0 && (!OUT_VALID || OUT_READY) && push.
  - Effect: OUT_D<=IN_D, OUT_VALID<=1.
  - This gives a 1-cycle latency from push to OUT_VALID when the FIFO is empty.
- Pop: on OUT_VALID && OUT_READY without bypass, OUT_VALID<=0. The next cycle is a refill if cnt!=0.
  - Sustained pop throughput is therefore 1 bit per 2 cycles from RAM.
  - Push and pop proceed together in the same write cycle.
- Full: cnt==32 forces IN_READY=0. Pushes stall even if OUT_VALID=0, because that state is always a refill cycle.
- Empty: cnt==0 && !OUT_VALID. RAM_WE=0 unless a push arrives, which then goes through bypass.
- Pointers wrap 31→0. cnt never exceeds 32 or underflows 0.
- Ordering is strictly FIFO, including across bypass. Bypass happens only when the RAM is empty.
- A push while IN_READY=0 is ignored with no side effects.

Optional Feature:
- Macro: BIT_FIFO32_LEVEL_EN.
- When defined, two extra outputs are added:
  - LEVEL[CNT_W-1:0] = cnt + OUT_VALID. Registered, range 0..33 (needs 6 bits).
  - OVF: sticky, set on the rising edge after any cycle with IN_VALID && !IN_READY && !refill && cnt==DEPTH, i.e. a push attempted while full. OVF is cleared only by reset.
- When undefined, neither port exists and there is no counter logic beyond cnt.

Decomposition:
- Shared package bit_fifo32_pkg holds:
  - ADDR_W and DEPTH constants.
  - Slot-type enum {SLOT_WRITE, SLOT_REFILL}.
  - CNT_W derivation.
- One natural sub-module, bit_fifo32_ptr: a wrap-around pointer register with increment enable, instanced for both wr_ptr and rd_ptr.
- The head register and slot arbitration stay in the top level.
- The bench instantiates the real 32x1 RAM model with WCLK=CLK.

Test Plan:
- Reset, then push 1 bit=1 into the empty FIFO with OUT_READY=0 → next cycle OUT_VALID=1, OUT_D=1, RAM_WE never asserted, cnt=0.
- Push 33 bits 0xA5A5A5A5 plus a trailing 1 with OUT_READY=0 → IN_READY drops after the 33rd accept. cnt=32; with the macro, LEVEL=33. A 34th push attempt sets OVF.
- From full, hold OUT_READY=1 → bits emerge in push order. OUT_VALID alternates 1/0 (refill every other cycle). After the wrap rd_ptr reads addresses 31→0 correctly. The FIFO ends empty with cnt=0.
- Continuous push and pop at cnt==0 with OUT_VALID=1 → every push takes the bypass path, 1 bit/cycle, RAM_WE stays 0.
- Fill 10 bits, assert RST_N low in mid-stream → OUT_VALID=0 and IN_READY=0 immediately. After release, push 0 → OUT_D=0 is seen first (no stale data).
- Push 32 bits while popping during refills, with random IN_VALID/OUT_READY over 2000 cycles → the scoreboard matches, cnt never exceeds 32, and RAM_WE=0 in every refill cycle.
